// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle datapath: ALU codes, ALU-B sources,
// instruction field positions and register-file geometry.
package cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_GPR   = 8;
  localparam int NUM_SR    = 8;
  localparam int REG_IDX_W = 3;
  localparam int IMM_W     = 6;
  localparam int TGT_W     = 12;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 0;

  localparam logic [6:0] ALU_ADD    = 7'd0;
  localparam logic [6:0] ALU_SUB    = 7'd1;
  localparam logic [6:0] ALU_AND    = 7'd2;
  localparam logic [6:0] ALU_OR     = 7'd3;
  localparam logic [6:0] ALU_XOR    = 7'd4;
  localparam logic [6:0] ALU_NOR    = 7'd5;
  localparam logic [6:0] ALU_SLT    = 7'd6;
  localparam logic [6:0] ALU_SLL    = 7'd7;
  localparam logic [6:0] ALU_SRL    = 7'd8;
  localparam logic [6:0] ALU_SRA    = 7'd9;
  localparam logic [6:0] ALU_PASS_B = 7'd10;

  localparam logic [1:0] ALUSRC_RT   = 2'd0;
  localparam logic [1:0] ALUSRC_SEXT = 2'd1;
  localparam logic [1:0] ALUSRC_ZEXT = 2'd2;
  localparam logic [1:0] ALUSRC_HI   = 2'd3;

  localparam logic [REG_IDX_W-1:0] SR_FLAGS_IDX = 3'd7;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  function automatic logic [DATA_W-1:0] sext_imm6(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: eleven operations plus {V,C,N,Z} flags. For SUB, C is the borrow
// (set when a < b unsigned); C and V are 0 for every non-arithmetic operation.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [6:0]        alu_op,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [DATA_W:0]   sum_w;
  logic        [3:0]        shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[3:0];

  always_comb begin
    sum_w  = '0;
    result = '0;
    flags  = '0;
    case (alu_op)
      ALU_ADD: begin
        sum_w   = {1'b0, a} + {1'b0, b};
        result  = sum_w[DATA_W-1:0];
        flags.c = sum_w[DATA_W];
        flags.v = (a[DATA_W-1] == b[DATA_W-1]) && (sum_w[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        sum_w   = {1'b0, a} - {1'b0, b};
        result  = sum_w[DATA_W-1:0];
        flags.c = sum_w[DATA_W];
        flags.v = (a[DATA_W-1] != b[DATA_W-1]) && (sum_w[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_NOR:    result = ~(a | b);
      ALU_SLT:    result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_SLL:    result = a << shamt;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = a_s >>> shamt;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
    flags.n = result[DATA_W-1];
    flags.z = (result == '0);
  end

endmodule

// File: rtl/cpu_datapath.sv
// 16-bit single-cycle CPU datapath: PC, 8x16 GPRs (R0 hard zero), ALU, data memory,
// 8 special registers and a sticky halt latch. Optional macro SR_FLAGS_EN makes SR7 a
// hardware-owned {V,C,N,Z} flag register.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic [6:0]        alu_op,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch_bneq,
  input  logic              branch_bgtz,
  input  logic              jump_abs,
  input  logic              jump_reg,
  input  logic [1:0]        alu_src,
  input  logic              mem_to_reg,
  input  logic              mtsr_write,
  input  logic              mfsr_read,
  input  logic [2:0]        special_sel,
  input  logic              rd_is_dest,
  input  logic              halt_decode,
  output logic [DATA_W-1:0] pc_out,
  output logic              halt
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  localparam logic signed [DATA_W-1:0] S_ZERO = '0;

  logic [REG_IDX_W-1:0]     rs_idx;
  logic [REG_IDX_W-1:0]     rt_idx;
  logic [REG_IDX_W-1:0]     rd_idx;
  logic [REG_IDX_W-1:0]     dest_idx;
  logic [IMM_W-1:0]         imm6;
  logic [TGT_W-1:0]         target12;
  logic [DATA_W-1:0]        rs_val;
  logic [DATA_W-1:0]        rt_val;
  logic signed [DATA_W-1:0] rs_signed;
  logic [DATA_W-1:0]        alu_b;
  logic [DATA_W-1:0]        alu_result;
  alu_flags_t               alu_flags;
  logic [DMEM_AW-1:0]       dmem_addr;
  logic [DATA_W-1:0]        mem_rdata;
  logic [DATA_W-1:0]        wb_data;
  logic [DATA_W-1:0]        pc_plus2;
  logic [DATA_W-1:0]        branch_off;
  logic                     take_branch;
  logic                     commit;

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  logic              halt_q;
  logic              halt_d;
  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] gpr_d [NUM_GPR];
  logic [DATA_W-1:0] sr_q  [NUM_SR];
  logic [DATA_W-1:0] sr_d  [NUM_SR];
  logic [DATA_W-1:0] dmem  [DMEM_DEPTH];

  assign rs_idx   = instruction[RS_MSB:RS_LSB];
  assign rt_idx   = instruction[RT_MSB:RT_LSB];
  assign rd_idx   = instruction[RD_MSB:RD_LSB];
  assign imm6     = instruction[IMM_MSB:IMM_LSB];
  assign target12 = instruction[TGT_MSB:TGT_LSB];

  assign rs_val    = (rs_idx == '0) ? '0 : gpr_q[rs_idx];
  assign rt_val    = (rt_idx == '0) ? '0 : gpr_q[rt_idx];
  assign rs_signed = rs_val;

  always_comb begin
    alu_b = rt_val;
    case (alu_src)
      ALUSRC_RT:   alu_b = rt_val;
      ALUSRC_SEXT: alu_b = sext_imm6(imm6);
      ALUSRC_ZEXT: alu_b = {{(DATA_W-IMM_W){1'b0}}, imm6};
      ALUSRC_HI:   alu_b = {imm6, {(DATA_W-IMM_W){1'b0}}};
      default:     alu_b = rt_val;
    endcase
  end

  cpu_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Byte address from the ALU; bit 0 is dropped to form the word index.
  assign dmem_addr = alu_result[DMEM_AW:1];
  assign mem_rdata = mem_read ? dmem[dmem_addr] : '0;

  always_comb begin
    wb_data = alu_result;
    if (mfsr_read) begin
      wb_data = sr_q[special_sel];
    end else if (mem_to_reg) begin
      wb_data = mem_rdata;
    end
  end

  assign dest_idx = rd_is_dest ? rd_idx : rt_idx;
  // A HALT instruction and an already-halted core both suppress every state write.
  assign commit   = !halt_q && !halt_decode;

  always_comb begin
    gpr_d = gpr_q;
    if (commit && reg_write && (dest_idx != '0)) begin
      gpr_d[dest_idx] = wb_data;
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (commit && mtsr_write) begin
      sr_d[special_sel] = rs_val;
    end
`ifdef SR_FLAGS_EN
    // Applied after the mtsr write so the hardware flag update wins on SR7.
    if (commit && reg_write && !mfsr_read && !mem_to_reg) begin
      sr_d[SR_FLAGS_IDX] = {{(DATA_W-4){1'b0}}, alu_flags};
    end
`endif
  end

  assign pc_plus2    = pc_q + DATA_W'(2);
  assign branch_off  = sext_imm6(imm6) << 1;
  assign take_branch = (branch_bneq && (rs_val != rt_val)) ||
                       (branch_bgtz && (rs_signed > S_ZERO));

  always_comb begin
    pc_d   = pc_plus2;
    halt_d = halt_q || halt_decode;
    if (halt_q || halt_decode) begin
      pc_d = pc_q;
    end else if (jump_reg) begin
      pc_d = rs_val;
    end else if (jump_abs) begin
      pc_d = {pc_plus2[DATA_W-1:TGT_W+1], target12, 1'b0};
    end else if (take_branch) begin
      pc_d = pc_plus2 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      halt_q <= 1'b0;
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      for (int i = 0; i < NUM_SR; i++)  sr_q[i]  <= '0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
      gpr_q  <= gpr_d;
      sr_q   <= sr_d;
    end
  end

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && mem_write) begin
      dmem[dmem_addr] <= rt_val;
    end
  end

  assign pc_out = pc_q;
  assign halt   = halt_q;

`ifdef SR_FLAGS_EN
  logic unused_bits;
  assign unused_bits = ^{instruction[OP_MSB:OP_LSB], alu_result[DATA_W-1:DMEM_AW+1],
                         alu_result[0]};
`else
  logic unused_bits;
  assign unused_bits = ^{instruction[OP_MSB:OP_LSB], alu_result[DATA_W-1:DMEM_AW+1],
                         alu_result[0], alu_flags};
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized bench for cpu_datapath against an arithmetic reference model; register
// contents are observed through pc_out by issuing jump_reg.
module tb_cpu_datapath;
  import cpu_pkg::*;

  typedef struct packed {
    logic [15:0] instr;
    logic [6:0]  alu_op;
    logic [1:0]  alu_src;
    logic [2:0]  sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        bneq;
    logic        bgtz;
    logic        jabs;
    logic        jreg;
    logic        mem_to_reg;
    logic        mtsr;
    logic        mfsr;
    logic        rd_dest;
    logic        hlt;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [6:0]  alu_op;
  logic        reg_write, mem_read, mem_write, branch_bneq, branch_bgtz;
  logic        jump_abs, jump_reg, mem_to_reg, mtsr_write, mfsr_read;
  logic        rd_is_dest, halt_decode;
  logic [1:0]  alu_src;
  logic [2:0]  special_sel;
  logic [15:0] pc_out;
  logic        halt;

  cpu_datapath #(.DMEM_DEPTH(1024), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_op(alu_op),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_bneq(branch_bneq), .branch_bgtz(branch_bgtz), .jump_abs(jump_abs),
    .jump_reg(jump_reg), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .mtsr_write(mtsr_write), .mfsr_read(mfsr_read), .special_sel(special_sel),
    .rd_is_dest(rd_is_dest), .halt_decode(halt_decode), .pc_out(pc_out), .halt(halt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_gpr [8];
  logic [15:0] m_sr  [8];
  logic [15:0] m_mem [1024];
  logic [15:0] m_pc;
  logic        m_halt;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input logic [15:0] v);
    int u = int'(v);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  function automatic logic [15:0] alu_ref(input logic [6:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = to_signed(a);
    int sb = to_signed(b);
    int sh = ub % 16;
    case (op)
      7'd0:    return 16'(ua + ub);
      7'd1:    return 16'(ua - ub);
      7'd2:    return a & b;
      7'd3:    return a | b;
      7'd4:    return a ^ b;
      7'd5:    return ~(a | b);
      7'd6:    return (sa < sb) ? 16'd1 : 16'd0;
      7'd7:    return 16'(ua * (2 ** sh));
      7'd8:    return 16'(ua / (2 ** sh));
      7'd9:    return 16'(sa >>> sh);
      7'd10:   return b;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] flags_ref(input logic [6:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] r);
    int s = 0;
    logic v = 1'b0, c = 1'b0;
    if (op == 7'd0) begin
      c = (int'(a) + int'(b)) >= 65536;
      s = to_signed(a) + to_signed(b);
      v = (s > 32767) || (s < -32768);
    end else if (op == 7'd1) begin
      c = a < b;
      s = to_signed(a) - to_signed(b);
      v = (s > 32767) || (s < -32768);
    end
    return {12'd0, v, c, r[15], (r == 16'd0)};
  endfunction

  task automatic model_reset();
    m_pc   = 16'h0000;
    m_halt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_gpr[i] = 16'h0;
      m_sr[i]  = 16'h0;
    end
  endtask

  task automatic model_exec(input ctrl_t c);
    logic [2:0]  rs, rt, dest;
    logic [5:0]  imm;
    logic [15:0] rsv, rtv, b, res, wb, npc;
    int          si, pc2, word;
    rs   = c.instr[11:9];
    rt   = c.instr[8:6];
    dest = c.rd_dest ? c.instr[5:3] : rt;
    imm  = c.instr[5:0];
    rsv  = m_gpr[rs];
    rtv  = m_gpr[rt];
    si   = imm[5] ? int'(imm) - 64 : int'(imm);
    case (c.alu_src)
      2'd0:    b = rtv;
      2'd1:    b = 16'(si);
      2'd2:    b = 16'(int'(imm));
      default: b = 16'(int'(imm) * 1024);
    endcase
    res  = alu_ref(c.alu_op, rsv, b);
    word = (int'(res) / 2) % 1024;
    if (c.mfsr)            wb = m_sr[c.sel];
    else if (c.mem_to_reg) wb = c.mem_read ? m_mem[word] : 16'h0;
    else                   wb = res;
    pc2 = (int'(m_pc) + 2) % 65536;
    if (c.jreg)      npc = rsv;
    else if (c.jabs) npc = 16'((pc2 & 'hE000) | (int'(c.instr[11:0]) * 2));
    else if ((c.bneq && rsv != rtv) || (c.bgtz && to_signed(rsv) > 0))
                     npc = 16'(pc2 + si * 2);
    else             npc = 16'(pc2);
    if (m_halt) begin
      // frozen until reset
    end else if (c.hlt) begin
      m_halt = 1'b1;
    end else begin
      if (c.mem_write) m_mem[word] = rtv;
      if (c.reg_write && dest != 3'd0) m_gpr[dest] = wb;
      if (c.mtsr) m_sr[c.sel] = rsv;
`ifdef SR_FLAGS_EN
      if (c.reg_write && !c.mfsr && !c.mem_to_reg) m_sr[7] = flags_ref(c.alu_op, rsv, b, res);
`endif
      m_pc = npc;
    end
  endtask

  task automatic drive(input ctrl_t c);
    instruction = c.instr;      alu_op      = c.alu_op;    alu_src     = c.alu_src;
    special_sel = c.sel;        reg_write   = c.reg_write; mem_read    = c.mem_read;
    mem_write   = c.mem_write;  branch_bneq = c.bneq;      branch_bgtz = c.bgtz;
    jump_abs    = c.jabs;       jump_reg    = c.jreg;      mem_to_reg  = c.mem_to_reg;
    mtsr_write  = c.mtsr;       mfsr_read   = c.mfsr;      rd_is_dest  = c.rd_dest;
    halt_decode = c.hlt;
  endtask

  task automatic step(input ctrl_t c);
    drive(c);
    model_exec(c);
    @(posedge clk);
    @(negedge clk);
    check("pc", pc_out, m_pc);
    check("halt", {15'd0, halt}, {15'd0, m_halt});
  endtask

  function automatic ctrl_t mk_rr(input logic [6:0] op, input logic [2:0] rd,
                                  input logic [2:0] rs, input logic [2:0] rt);
    ctrl_t c = '0;
    c.alu_op = op; c.reg_write = 1'b1; c.rd_dest = 1'b1;
    c.instr = {4'h0, rs, rt, rd, 3'b000};
    return c;
  endfunction

  function automatic ctrl_t mk_ri(input logic [6:0] op, input logic [2:0] rt,
                                  input logic [2:0] rs, input logic [1:0] src,
                                  input logic [5:0] imm);
    ctrl_t c = '0;
    c.alu_op = op; c.reg_write = 1'b1; c.alu_src = src;
    c.instr = {4'h0, rs, rt, imm};
    return c;
  endfunction

  task automatic load_const(input logic [2:0] r, input logic [15:0] v);
    step(mk_ri(ALU_ADD, r, 3'd0, ALUSRC_ZEXT, v[15:10]));
    step(mk_ri(ALU_SLL, r, r, ALUSRC_ZEXT, 6'd6));
    step(mk_ri(ALU_OR,  r, r, ALUSRC_ZEXT, v[9:4]));
    step(mk_ri(ALU_SLL, r, r, ALUSRC_ZEXT, 6'd4));
    step(mk_ri(ALU_OR,  r, r, ALUSRC_ZEXT, {2'b00, v[3:0]}));
  endtask

  task automatic peek(input string tag, input logic [2:0] r, input logic [15:0] exp);
    ctrl_t c = '0;
    c.jreg  = 1'b1;
    c.instr = {4'h0, r, 9'h000};
    step(c);
    check(tag, pc_out, exp);
  endtask

  task automatic pulse_reset(input string tag);
    drive('0);
    #2 reset = 1'b0;
    #1;
    check({tag, "_pc"}, pc_out, 16'h0000);
    check({tag, "_halt"}, {15'd0, halt}, 16'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic ctrl_t rand_ctrl();
    ctrl_t c = '0;
    int    kind = $urandom_range(0, 9);
    c.instr = 16'($urandom);
    case (kind)
      0, 1, 2: begin
        c.alu_op = 7'($urandom_range(0, 12)); c.alu_src = 2'($urandom);
        c.rd_dest = 1'($urandom); c.reg_write = 1'b1;
      end
      3: begin
        c.alu_src = ALUSRC_ZEXT; c.instr[11:9] = 3'd0; c.mem_write = 1'b1;
      end
      4: begin
        c.alu_src = ALUSRC_ZEXT; c.instr[11:9] = 3'd0; c.mem_read = 1'b1;
        c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
      end
      5: begin
        c.bneq = 1'($urandom); c.bgtz = !c.bneq;
      end
      6: c.jabs = 1'b1;
      7: c.jreg = 1'b1;
      8: begin
        c.mtsr = 1'b1; c.sel = 3'($urandom); c.reg_write = 1'($urandom);
        c.alu_op = 7'($urandom_range(0, 10)); c.rd_dest = 1'b1;
      end
      default: begin
        c.mfsr = 1'b1; c.sel = 3'($urandom); c.reg_write = 1'b1; c.rd_dest = 1'($urandom);
      end
    endcase
    return c;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_t       c;
    logic [15:0] hold_pc;
    logic [63:0] rbits;
    reset = 1'b0;
    drive('0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc", pc_out, 16'h0000);
    check("rst_halt", {15'd0, halt}, 16'd0);
    reset = 1'b1;

    for (int r = 1; r < 8; r++) load_const(3'(r), 16'($urandom));
    for (int w = 0; w < 32; w++) begin
      c = mk_ri(ALU_ADD, 3'($urandom_range(0, 7)), 3'd0, ALUSRC_ZEXT, 6'(w * 2));
      c.reg_write = 1'b0;
      c.mem_write = 1'b1;
      step(c);
    end

    repeat (600) step(rand_ctrl());
    for (int r = 0; r < 8; r++) peek("rand_reg", 3'(r), m_gpr[r]);

    pulse_reset("midrun");
    step(mk_rr(ALU_ADD, 3'd2, 3'd1, 3'd0));
    peek("rst_r1", 3'd2, 16'h0000);

    step(mk_ri(ALU_ADD, 3'd1, 3'd0, ALUSRC_SEXT, 6'h3F));
    peek("add_imm", 3'd1, 16'hFFFF);
    step(mk_rr(ALU_SUB, 3'd2, 3'd1, 3'd1));
    peek("sub", 3'd2, 16'h0000);
    step(mk_rr(ALU_SLT, 3'd3, 3'd1, 3'd2));
    peek("slt", 3'd3, 16'h0001);

    load_const(3'd1, 16'h1234);
    c = mk_ri(ALU_ADD, 3'd1, 3'd0, ALUSRC_ZEXT, 6'h10);
    c.reg_write = 1'b0; c.mem_write = 1'b1;
    step(c);
    c = mk_ri(ALU_ADD, 3'd4, 3'd0, ALUSRC_ZEXT, 6'h10);
    c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
    step(c);
    peek("load", 3'd4, 16'h1234);
    step(mk_rr(ALU_ADD, 3'd0, 3'd1, 3'd0));
    peek("r0_zero", 3'd0, 16'h0000);

    load_const(3'd6, 16'h0020);
    load_const(3'd1, 16'h8000);
    peek("jr_20", 3'd6, 16'h0020);
    c = '0; c.bneq = 1'b1; c.instr = {4'h0, 3'd1, 3'd2, 6'h3E};
    step(c);
    check("bneq_taken", pc_out, 16'h001E);
    peek("jr_20b", 3'd6, 16'h0020);
    c = '0; c.bgtz = 1'b1; c.instr = {4'h0, 3'd1, 3'd2, 6'h3E};
    step(c);
    check("bgtz_neg", pc_out, 16'h0022);
    load_const(3'd5, 16'h4000);
    peek("jr_4000", 3'd5, 16'h4000);
    c = '0; c.jabs = 1'b1; c.instr = 16'h0123;
    step(c);
    check("jabs", pc_out, 16'h4246);
    load_const(3'd7, 16'h00A0);
    peek("jreg", 3'd7, 16'h00A0);

    load_const(3'd3, 16'hBEEF);
    c = '0; c.mtsr = 1'b1; c.sel = 3'd2; c.instr = {4'h0, 3'd3, 9'h000};
    step(c);
    c = '0; c.mfsr = 1'b1; c.sel = 3'd2; c.reg_write = 1'b1; c.rd_dest = 1'b1;
    c.instr = {4'h0, 6'h00, 3'd5, 3'b000};
    step(c);
    peek("mfsr", 3'd5, 16'hBEEF);

    load_const(3'd1, 16'h5A5A);
    hold_pc = m_pc;
    c = mk_ri(ALU_ADD, 3'd1, 3'd0, ALUSRC_ZEXT, 6'h03);
    c.hlt = 1'b1;
    step(c);
    check("halt_set", {15'd0, halt}, 16'd1);
    for (int i = 0; i < 10; i++) begin
      rbits = {$urandom, $urandom};
      step(ctrl_t'(rbits[$bits(ctrl_t)-1:0]));
      check("halt_pc", pc_out, hold_pc);
      check("halt_r1", dut.gpr_q[1], 16'h5A5A);
    end
    pulse_reset("halt_clr");
    step('0);
    check("post_halt_pc", pc_out, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
